// File: rtl/wb_arb_pkg.sv
// Shared types for the two-master round-robin Wishbone arbiter.
package wb_arb_pkg;

    localparam int NB_MASTERS = 2;

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} arb_state_t;

    typedef logic mst_idx_t;

endpackage

// File: rtl/wshb_if.sv
// Classic Wishbone bus bundle; master drives the request, slave drives the response.
interface wshb_if #(
    parameter int DW = 32,
    parameter int AW = 32
) ();
    logic            cyc;
    logic            stb;
    logic            we;
    logic [DW/8-1:0] sel;
    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat_ms;
    logic [DW-1:0]   dat_sm;
    logic            ack;
    logic            err;
    logic            rty;
    logic [2:0]      cti;
    logic [1:0]      bte;

    modport master (
        output cyc, stb, we, sel, adr, dat_ms, cti, bte,
        input  ack, err, rty, dat_sm
    );

    modport slave (
        input  cyc, stb, we, sel, adr, dat_ms, cti, bte,
        output ack, err, rty, dat_sm
    );
endinterface

// File: rtl/wb_arb_wdog.sv
// Stall watchdog: pulses o_timeout when a granted strobe waits TIMEOUT_CYCLES without response.
module wb_arb_wdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_active,
    input  logic i_stb,
    input  logic i_resp,
    output logic o_timeout
);
    localparam int                CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] r_cnt;

    assign o_timeout = i_active & i_stb & (r_cnt == LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!i_active || i_resp || o_timeout) begin
            r_cnt <= '0;
        end else if (i_stb) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/wb_arbiter_rr.sv
// Two-master round-robin Wishbone arbiter, grant locked for the whole bus cycle.
// Optional stall watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter_rr
    import wb_arb_pkg::*;
#(
    parameter int ADR_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic   clk,
    input  logic   rst,
    wshb_if.slave  wb_m0,
    wshb_if.slave  wb_m1,
    wshb_if.master wb_s
);
    arb_state_t            r_state;
    arb_state_t            w_next_state;
    mst_idx_t              r_last_gnt;
    logic [NB_MASTERS-1:0] w_gnt;
    logic                  w_timeout;
    logic [ADR_WIDTH-1:0]  w_adr;

    // NOTE: asynchronous reset in the sensitivity list; all state uses non-blocking assignments.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_last_gnt <= mst_idx_t'(1);
        end else begin
            r_state <= w_next_state;
            if (r_state == GNT0 && !wb_m0.cyc) begin
                r_last_gnt <= mst_idx_t'(0);
            end else if (r_state == GNT1 && !wb_m1.cyc) begin
                r_last_gnt <= mst_idx_t'(1);
            end
        end
    end

    // Releasing always passes through IDLE, so a new owner is picked one cycle later.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (wb_m0.cyc && wb_m1.cyc) begin
                    w_next_state = (r_last_gnt == mst_idx_t'(1)) ? GNT0 : GNT1;
                end else if (wb_m0.cyc) begin
                    w_next_state = GNT0;
                end else if (wb_m1.cyc) begin
                    w_next_state = GNT1;
                end
            end
            GNT0:    if (!wb_m0.cyc) w_next_state = IDLE;
            GNT1:    if (!wb_m1.cyc) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    assign w_gnt = {r_state == GNT1, r_state == GNT0};

`ifdef WB_ARB_TIMEOUT_EN
    logic w_gnt_stb;
    logic w_slv_resp;

    assign w_gnt_stb  = (w_gnt[0] & wb_m0.stb) | (w_gnt[1] & wb_m1.stb);
    assign w_slv_resp = wb_s.ack | wb_s.err | wb_s.rty;

    wb_arb_wdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk       (clk),
        .rst_n     (rst),
        .i_active  (|w_gnt),
        .i_stb     (w_gnt_stb),
        .i_resp    (w_slv_resp),
        .o_timeout (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    // NOTE: every output gets a default first so this block never infers a latch.
    always_comb begin
        wb_s.cyc     = 1'b0;
        wb_s.stb     = 1'b0;
        wb_s.we      = 1'b0;
        wb_s.sel     = '0;
        wb_s.dat_ms  = '0;
        wb_s.cti     = '0;
        wb_s.bte     = '0;
        w_adr        = '0;
        wb_m0.ack    = 1'b0;
        wb_m0.err    = 1'b0;
        wb_m0.rty    = 1'b0;
        wb_m0.dat_sm = '0;
        wb_m1.ack    = 1'b0;
        wb_m1.err    = 1'b0;
        wb_m1.rty    = 1'b0;
        wb_m1.dat_sm = '0;
        if (w_gnt[0]) begin
            wb_s.cyc     = wb_m0.cyc & ~w_timeout;
            wb_s.stb     = wb_m0.stb & ~w_timeout;
            wb_s.we      = wb_m0.we;
            wb_s.sel     = wb_m0.sel;
            wb_s.dat_ms  = wb_m0.dat_ms;
            wb_s.cti     = wb_m0.cti;
            wb_s.bte     = wb_m0.bte;
            w_adr        = wb_m0.adr;
            wb_m0.ack    = wb_s.ack;
            wb_m0.err    = wb_s.err | w_timeout;
            wb_m0.rty    = wb_s.rty;
            wb_m0.dat_sm = wb_s.dat_sm;
        end else if (w_gnt[1]) begin
            wb_s.cyc     = wb_m1.cyc & ~w_timeout;
            wb_s.stb     = wb_m1.stb & ~w_timeout;
            wb_s.we      = wb_m1.we;
            wb_s.sel     = wb_m1.sel;
            wb_s.dat_ms  = wb_m1.dat_ms;
            wb_s.cti     = wb_m1.cti;
            wb_s.bte     = wb_m1.bte;
            w_adr        = wb_m1.adr;
            wb_m1.ack    = wb_s.ack;
            wb_m1.err    = wb_s.err | w_timeout;
            wb_m1.rty    = wb_s.rty;
            wb_m1.dat_sm = wb_s.dat_sm;
        end
        wb_s.adr = w_adr;
    end
endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Self-checking bench for wb_arbiter_rr: bus-owner model, memory slave, directed scenarios.
module tb_wb_arbiter_rr;
    localparam int TO = 8;

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [2:0]  cti;
        logic [1:0]  bte;
    } req_t;

    logic clk = 1'b0;
    logic rst;
    logic ack_en;

    always #5 clk = ~clk;

    wshb_if m0_if ();
    wshb_if m1_if ();
    wshb_if s_if ();

    wb_arbiter_rr #(
        .ADR_WIDTH      (32),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .wb_m0 (m0_if),
        .wb_m1 (m1_if),
        .wb_s  (s_if)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory slave: one-cycle registered ack, word-addressed by adr[5:0].
    logic [31:0] mem [64];
    assign s_if.err = 1'b0;
    assign s_if.rty = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_if.ack    <= 1'b0;
            s_if.dat_sm <= '0;
            for (int i = 0; i < 64; i++) mem[i] <= 32'hA000_0000 + i;
        end else begin
            s_if.ack <= 1'b0;
            if (s_if.cyc && s_if.stb && !s_if.ack && ack_en) begin
                s_if.ack <= 1'b1;
                if (s_if.we) begin
                    for (int b = 0; b < 4; b++)
                        if (s_if.sel[b]) mem[s_if.adr[5:0]][8*b +: 8] <= s_if.dat_ms[8*b +: 8];
                end else begin
                    s_if.dat_sm <= mem[s_if.adr[5:0]];
                end
            end
        end
    end

    function automatic req_t get_req(input int i);
        req_t r;
        if (i == 0) r = {m0_if.cyc, m0_if.stb, m0_if.we, m0_if.sel, m0_if.adr, m0_if.dat_ms, m0_if.cti, m0_if.bte};
        else        r = {m1_if.cyc, m1_if.stb, m1_if.we, m1_if.sel, m1_if.adr, m1_if.dat_ms, m1_if.cti, m1_if.bte};
        return r;
    endfunction

    function automatic req_t mk(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [2:0] cti);
        req_t r;
        r = '{cyc: 1'b1, stb: 1'b1, we: we, sel: 4'hF, adr: adr, dat: dat, cti: cti, bte: 2'b01};
        return r;
    endfunction

    task automatic set_req(input int i, input req_t r);
        if (i == 0) begin
            m0_if.cyc = r.cyc; m0_if.stb = r.stb; m0_if.we = r.we; m0_if.sel = r.sel;
            m0_if.adr = r.adr; m0_if.dat_ms = r.dat; m0_if.cti = r.cti; m0_if.bte = r.bte;
        end else begin
            m1_if.cyc = r.cyc; m1_if.stb = r.stb; m1_if.we = r.we; m1_if.sel = r.sel;
            m1_if.adr = r.adr; m1_if.dat_ms = r.dat; m1_if.cti = r.cti; m1_if.bte = r.bte;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bus-owner model: owner is -1 when nobody holds the bus; a tie goes to whoever did not own it last.
    int owner    = -1;
    int last_own = 1;
    int stall    = 0;

    function automatic logic exp_to();
`ifdef WB_ARB_TIMEOUT_EN
        req_t r;
        if (owner < 0) return 1'b0;
        r = get_req(owner);
        return r.stb && (stall == TO);
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner    <= -1;
            last_own <= 1;
            stall    <= 0;
        end else begin
            req_t r0, r1, ro;
            r0 = get_req(0);
            r1 = get_req(1);
            ro = (owner == 1) ? r1 : r0;
            if (owner < 0 || s_if.ack || exp_to()) stall <= 0;
            else if (ro.stb) stall <= stall + 1;
            if (owner < 0) begin
                if (r0.cyc && r1.cyc) owner <= 1 - last_own;
                else if (r0.cyc)      owner <= 0;
                else if (r1.cyc)      owner <= 1;
            end else if (!ro.cyc) begin
                last_own <= owner;
                owner    <= -1;
            end
        end
    end

    // Every-cycle comparison of all DUT outputs against the model.
    always @(negedge clk) begin
        req_t        r;
        logic        to;
        logic [34:0] rsp;
        to  = exp_to();
        r   = '0;
        rsp = {s_if.ack, s_if.err | to, s_if.rty, s_if.dat_sm};
        if (owner >= 0) begin
            r     = get_req(owner);
            r.cyc = r.cyc & ~to;
            r.stb = r.stb & ~to;
        end
        check("s_side", {s_if.cyc, s_if.stb, s_if.we, s_if.sel, s_if.adr, s_if.dat_ms, s_if.cti, s_if.bte}, r);
        check("m0_rsp", {m0_if.ack, m0_if.err, m0_if.rty, m0_if.dat_sm}, (owner == 0) ? rsp : 35'h0);
        check("m1_rsp", {m1_if.ack, m1_if.err, m1_if.rty, m1_if.dat_sm}, (owner == 1) ? rsp : 35'h0);
    end

    int m0_ack_cnt = 0;
    always @(negedge clk) if (m0_if.ack === 1'b1) m0_ack_cnt <= m0_ack_cnt + 1;

    // Waits for ack on master i, returns negedges waited and read data, then drops stb (cyc kept).
    task automatic wait_ack(input int i, output int lat, output logic [31:0] rd);
        logic got;
        got = 1'b0;
        lat = 0;
        rd  = '0;
        for (int k = 0; k < 30 && !got; k++) begin
            @(negedge clk);
            lat++;
            if (((i == 0) ? m0_if.ack : m1_if.ack) === 1'b1) begin
                got = 1'b1;
                rd  = (i == 0) ? m0_if.dat_sm : m1_if.dat_sm;
            end
        end
        check($sformatf("ack_seen_m%0d", i), got, 1'b1);
        tick();
        if (i == 0) m0_if.stb = 1'b0;
        else        m1_if.stb = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_time_limit reached");
        $fatal(1, "bench did not terminate");
    end

    initial begin
        int          lat;
        int          cnt;
        int          acks_before;
        logic [31:0] rd;
        logic        seen;

        rst    = 1'b0;
        ack_en = 1'b1;
        set_req(0, '0);
        set_req(1, '0);
        repeat (3) tick();
        check("rst_s_cyc", s_if.cyc, 1'b0);
        check("rst_acks", {m0_if.ack, m1_if.ack}, 2'b00);
        rst = 1'b1;

        // Single write then read-back by m0.
        set_req(0, mk(1'b1, 32'h10, 32'hDEAD_BEEF, 3'b111));
        wait_ack(0, lat, rd);
        check("wr_lat", lat, 3);
        check("mem_wr", mem[16], 32'hDEAD_BEEF);
        set_req(0, mk(1'b0, 32'h10, 32'h0, 3'b111));
        wait_ack(0, lat, rd);
        check("rd_lat", lat, 2);
        check("rd_data", rd, 32'hDEAD_BEEF);
        set_req(0, '0);
        tick();

        // Tie after reset: m0 first, one idle cycle, then m1.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        set_req(0, mk(1'b0, 32'h1, 32'h0, 3'b000));
        set_req(1, mk(1'b0, 32'h2, 32'h0, 3'b000));
        wait_ack(0, lat, rd);
        check("tie_m0_lat", lat, 3);
        check("tie_m0_dat", rd, 32'hA000_0001);
        set_req(0, '0);
        wait_ack(1, lat, rd);
        check("handover_lat", lat, 4);
        check("handover_dat", rd, 32'hA000_0002);
        set_req(1, '0);
        tick();
        set_req(0, mk(1'b0, 32'h3, 32'h0, 3'b000));
        wait_ack(0, lat, rd);
        check("solo_m0_dat", rd, 32'hA000_0003);
        set_req(0, '0);
        tick();

        // Tie after m0 owned last: m1 wins, then keeps the bus for a locked burst.
        acks_before = m0_ack_cnt;
        set_req(0, mk(1'b0, 32'h5, 32'h0, 3'b000));
        set_req(1, mk(1'b0, 32'h0, 32'h0, 3'b010));
        wait_ack(1, lat, rd);
        check("alt_m1_lat", lat, 3);
        check("alt_m1_dat", rd, 32'hA000_0000);
        tick();
        for (int k = 1; k < 4; k++) begin
            set_req(1, mk(1'b0, k, 32'h0, 3'b010));
            wait_ack(1, lat, rd);
            check($sformatf("burst_dat%0d", k), rd, 32'hA000_0000 + k);
            tick();
        end
        check("burst_m0_noack", m0_ack_cnt, acks_before);
        set_req(1, '0);
        wait_ack(0, lat, rd);
        check("after_burst_lat", lat, 4);
        check("after_burst_dat", rd, 32'hA000_0005);
        set_req(0, '0);
        repeat (2) tick();

        // Asynchronous reset while m0 waits for its read ack.
        set_req(0, mk(1'b0, 32'h6, 32'h0, 3'b000));
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            seen = s_if.stb;
        end
        check("arst_stb_seen", seen, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("arst_s_cyc_stb", {s_if.cyc, s_if.stb}, 2'b00);
        check("arst_m0_ack", m0_if.ack, 1'b0);
        @(negedge clk);
        check("arst_m0_ack_next", m0_if.ack, 1'b0);
        set_req(0, '0);
        tick();
        rst = 1'b1;
        tick();

        // Stalled slave.
        ack_en = 1'b0;
        set_req(0, mk(1'b0, 32'h8, 32'h0, 3'b000));
`ifdef WB_ARB_TIMEOUT_EN
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            seen = s_if.stb;
        end
        check("to_stb_seen", seen, 1'b1);
        cnt  = 0;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            cnt++;
            seen = m0_if.err;
        end
        check("to_lat", cnt, TO);
        check("to_stb_forced", {s_if.cyc, s_if.stb}, 2'b00);
        tick();
        set_req(0, '0);
`else
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (m0_if.err !== 1'b0) cnt++;
        end
        check("no_err_100", cnt, 0);
        check("stall_still_fwd", s_if.stb, 1'b1);
        tick();
        set_req(0, '0);
`endif
        ack_en = 1'b1;
        repeat (2) tick();

        // m0 releases while m1 requests in the same cycle.
        set_req(0, mk(1'b0, 32'h7, 32'h0, 3'b000));
        wait_ack(0, lat, rd);
        check("sw_m0_dat", rd, 32'hA000_0007);
        set_req(0, '0);
        set_req(1, mk(1'b0, 32'h2A, 32'h0, 3'b001));
        @(negedge clk);
        check("sw_n1_cyc", s_if.cyc, 1'b0);
        @(negedge clk);
        check("sw_idle", {s_if.cyc, s_if.adr}, 33'h0);
        @(negedge clk);
        check("sw_gnt1", {s_if.cyc, s_if.adr}, {1'b1, 32'h2A});
        wait_ack(1, lat, rd);
        check("sw_m1_lat", lat, 1);
        check("sw_m1_dat", rd, 32'hA000_002A);
        set_req(1, '0);
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
